// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI subset types for the SRAM responder and its bus masters.
// Data width, burst length and response encodings live here.
package axi_sram_responder_pkg;

   localparam int AXI_DATA_WIDTH = 32;

   typedef logic [7:0] axi_burst_len_t;
   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_interface.sv
// Simplified AXI bundle between the L2 bus interface and a responder.
// Burst type is always INCR; no ids, no strobes.
interface axi_interface;
   import axi_sram_responder_pkg::*;

   logic [31:0]               awaddr;
   axi_burst_len_t            awlen;
   logic                      awvalid;
   logic                      awready;
   logic [31:0]               araddr;
   axi_burst_len_t            arlen;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_DATA_WIDTH-1:0] wdata;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic                      bvalid;
   logic                      bready;
   axi_resp_t                 bresp;
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;

   modport slave (
      input  awaddr, awlen, awvalid,
      input  araddr, arlen, arvalid,
      input  wdata, wlast, wvalid,
      input  bready, rready,
      output awready, arready, wready,
      output bvalid, bresp,
      output rdata, rlast, rvalid
   );

   modport master (
      output awaddr, awlen, awvalid,
      output araddr, arlen, arvalid,
      output wdata, wlast, wvalid,
      output bready, rready,
      input  awready, arready, wready,
      input  bvalid, bresp,
      input  rdata, rlast, rvalid
   );

endinterface

// File: rtl/axi_sram_responder_sram.sv
// Synchronous SRAM, one read or write per cycle, 1-cycle read latency.
// Output register only updates on read enable so data can be held.
module sram_1r1w #(
   parameter int DEPTH = 16384,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // storage array with registered read port
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI responder serving one INCR burst at a time from a local SRAM.
// Writes win over reads when both address channels arrive together.
module axi_sram_responder
   import axi_sram_responder_pkg::*;
#(
   parameter int MEM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        reset_n,
   axi_interface.slave axi_bus,
   output logic        protocol_error
);

   localparam int ADDR_WIDTH = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {
      IDLE,
      WRITE_BURST,
      WRITE_RESP,
      READ_BURST
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [ADDR_WIDTH-1:0]     sram_addr;
   axi_burst_len_t            len_q;
   axi_burst_len_t            cnt_q;
   logic [AXI_DATA_WIDTH-1:0] sram_q;
   logic                      sram_we;
   logic                      sram_re;
   logic                      last_beat;
   logic                      aw_go;
   logic                      ar_go;

   assign last_beat = (cnt_q == len_q);
   assign aw_go = (state == IDLE) && axi_bus.awvalid;
   assign ar_go = (state == IDLE) && !axi_bus.awvalid
                  && axi_bus.arvalid;

   assign axi_bus.bresp = RESP_OKAY;
   assign axi_bus.rlast = (state == READ_BURST) && last_beat;
   assign axi_bus.rdata = (state == READ_BURST) ? sram_q : '0;

   // state register; reset aborts any burst in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next state, handshake outputs and shared SRAM port steering
   always_comb begin
      state_nxt       = state;
      axi_bus.awready = 1'b0;
      axi_bus.arready = 1'b0;
      axi_bus.wready  = 1'b0;
      axi_bus.bvalid  = 1'b0;
      axi_bus.rvalid  = 1'b0;
      sram_we         = 1'b0;
      sram_re         = 1'b0;
      sram_addr       = addr_q;
      unique case (state)
         IDLE: begin
            axi_bus.awready = reset_n;
            axi_bus.arready = reset_n && !axi_bus.awvalid;
            if (aw_go) begin
               state_nxt = WRITE_BURST;
            end else if (ar_go) begin
               state_nxt = READ_BURST;
               sram_re   = 1'b1;
               sram_addr = axi_bus.araddr[ADDR_WIDTH+1:2];
            end
         end
         WRITE_BURST: begin
            axi_bus.wready = 1'b1;
            if (axi_bus.wvalid) begin
               sram_we = 1'b1;
               if (last_beat) state_nxt = WRITE_RESP;
            end
         end
         WRITE_RESP: begin
            axi_bus.bvalid = 1'b1;
            if (axi_bus.bready) state_nxt = IDLE;
         end
         READ_BURST: begin
            axi_bus.rvalid = 1'b1;
            if (axi_bus.rready) begin
               if (last_beat) begin
                  state_nxt = IDLE;
               end else begin
                  sram_re   = 1'b1;
                  sram_addr = addr_q + ADDR_WIDTH'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // burst address, beat counter and sticky wlast checker
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q         <= '0;
         len_q          <= '0;
         cnt_q          <= '0;
         protocol_error <= 1'b0;
      end else if (aw_go) begin
         addr_q <= axi_bus.awaddr[ADDR_WIDTH+1:2];
         len_q  <= axi_bus.awlen;
         cnt_q  <= '0;
      end else if (ar_go) begin
         addr_q <= axi_bus.araddr[ADDR_WIDTH+1:2];
         len_q  <= axi_bus.arlen;
         cnt_q  <= '0;
      end else if (state == WRITE_BURST && axi_bus.wvalid) begin
         addr_q <= addr_q + ADDR_WIDTH'(1);
         cnt_q  <= cnt_q + 8'd1;
         if (axi_bus.wlast != last_beat) protocol_error <= 1'b1;
      end else if (state == READ_BURST && axi_bus.rready
                   && !last_beat) begin
         addr_q <= addr_q + ADDR_WIDTH'(1);
         cnt_q  <= cnt_q + 8'd1;
      end
   end

   sram_1r1w #(
      .DEPTH (MEM_WORDS),
      .WIDTH (AXI_DATA_WIDTH)
   ) u_sram (
      .clk   (clk),
      .we    (sram_we),
      .re    (sram_re),
      .addr  (sram_addr),
      .wdata (axi_bus.wdata),
      .rdata (sram_q)
   );

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: bursts, arbitration, stalls,
// wlast checking, address wrap and mid-burst reset.
module tb_axi_sram_responder;
   import axi_sram_responder_pkg::*;

   localparam int MEM_WORDS = 16384;

   logic clk = 1'b0;
   logic reset_n;
   logic protocol_error;

   axi_interface bus();

   axi_sram_responder #(
      .MEM_WORDS (MEM_WORDS)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .axi_bus        (bus),
      .protocol_error (protocol_error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   logic perr_exp;
   logic [AXI_DATA_WIDTH-1:0] model [int];
   logic [AXI_DATA_WIDTH:0]   sb [$];

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic aw_phase(input logic [31:0] a, input int len,
                           input bit with_ar);
      int n = 0;
      @(negedge clk);
      bus.awaddr  = a;
      bus.awlen   = 8'(len);
      bus.awvalid = 1'b1;
      if (with_ar) begin
         bus.araddr  = a;
         bus.arlen   = 8'(len);
         bus.arvalid = 1'b1;
      end
      #1;
      while (!bus.awready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("aw_wait", 64'(n < 50), 1);
      check("ar_blocked", bus.arready, 0);
   endtask

   task automatic w_phase(input logic [31:0] a, input int len,
                          input logic [31:0] base, input int early);
      int w = int'((a >> 2) % MEM_WORDS);
      for (int b = 0; b <= len; b++) begin
         @(negedge clk);
         bus.awvalid = 1'b0;
         bus.wvalid  = 1'b1;
         bus.wdata   = base + b;
         bus.wlast   = (b == len) || (b == early);
         #1;
         check("wready", bus.wready, 1);
         check("ar_hold", bus.arready, 0);
         check("perr_w", protocol_error, perr_exp);
         model[(w + b) % MEM_WORDS] = base + b;
         if (bus.wlast != (b == len)) perr_exp = 1'b1;
      end
   endtask

   task automatic b_phase();
      @(negedge clk);
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      #1;
      check("bvalid", bus.bvalid, 1);
      check("perr_b", protocol_error, perr_exp);
      @(negedge clk);
      #1;
      check("bvalid_hold", bus.bvalid, 1);
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      #1;
      check("bvalid_clr", bus.bvalid, 0);
      check("aw_ready_idle", bus.awready, 1);
   endtask

   task automatic ar_phase(input logic [31:0] a, input int len);
      int n = 0;
      @(negedge clk);
      bus.araddr  = a;
      bus.arlen   = 8'(len);
      bus.arvalid = 1'b1;
      #1;
      while (!bus.arready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("ar_wait", 64'(n < 50), 1);
   endtask

   task automatic r_phase(input logic [31:0] a, input int len,
                          input int mode, input int abort_at,
                          output int cyc);
      int w = int'((a >> 2) % MEM_WORDS);
      int beats = 0;
      logic held_v = 1'b0;
      logic [AXI_DATA_WIDTH:0] held;
      logic [AXI_DATA_WIDTH:0] exp;
      for (int b = 0; b <= len; b++)
         sb.push_back({1'(b == len), model[(w + b) % MEM_WORDS]});
      cyc = 0;
      while (beats <= len && cyc < 100) begin
         @(negedge clk);
         bus.arvalid = 1'b0;
         bus.rready  = (mode == 0) || (cyc % 3 == 0);
         #1;
         cyc++;
         if (beats == abort_at) begin
            reset_n = 1'b0;
            #1;
            check("rst_awready", bus.awready, 0);
            check("rst_arready", bus.arready, 0);
            check("rst_wready", bus.wready, 0);
            check("rst_bvalid", bus.bvalid, 0);
            check("rst_rvalid", bus.rvalid, 0);
            check("rst_rlast", bus.rlast, 0);
            check("rst_perr", protocol_error, 0);
            bus.rready = 1'b0;
            sb.delete();
            return;
         end
         check("rvalid", bus.rvalid, 1);
         if (held_v)
            check("r_stable", {bus.rlast, bus.rdata}, held);
         if (bus.rready) begin
            if (sb.size() == 0) begin
               check("sb_empty", 1, 0);
            end else begin
               exp = sb.pop_front();
               check("rbeat", {bus.rlast, bus.rdata}, exp);
            end
            beats++;
            held_v = 1'b0;
         end else begin
            held   = {bus.rlast, bus.rdata};
            held_v = 1'b1;
         end
      end
      check("r_done", beats, len + 1);
      @(negedge clk);
      bus.rready = 1'b0;
      #1;
      check("rvalid_clr", bus.rvalid, 0);
   endtask

   initial begin
      int cyc;
      reset_n     = 1'b1;
      perr_exp    = 1'b0;
      bus.awaddr  = '0;
      bus.awlen   = '0;
      bus.awvalid = 1'b0;
      bus.araddr  = '0;
      bus.arlen   = '0;
      bus.arvalid = 1'b0;
      bus.wdata   = '0;
      bus.wlast   = 1'b0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.rready  = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_awready", bus.awready, 0);
      check("reset_arready", bus.arready, 0);
      check("reset_rvalid", bus.rvalid, 0);
      check("reset_bvalid", bus.bvalid, 0);
      check("reset_perr", protocol_error, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("idle_awready", bus.awready, 1);
      check("idle_arready", bus.arready, 1);

      aw_phase(32'h1000, 15, 1'b0);
      w_phase(32'h1000, 15, 32'hA0, -1);
      b_phase();
      ar_phase(32'h1000, 15);
      r_phase(32'h1000, 15, 0, -1, cyc);
      check("b2b_cycles", cyc, 16);

      aw_phase(32'h2000, 3, 1'b1);
      w_phase(32'h2000, 3, 32'h55AA_0000, -1);
      b_phase();
      check("ar_after_b", bus.arready, 1);
      r_phase(32'h2000, 3, 0, -1, cyc);

      ar_phase(32'h1000, 15);
      r_phase(32'h1000, 15, 1, -1, cyc);

      aw_phase(32'h3000, 3, 1'b0);
      w_phase(32'h3000, 3, 32'hC0, 1);
      b_phase();
      check("perr_set", protocol_error, 1);
      ar_phase(32'h3000, 3);
      r_phase(32'h3000, 3, 0, -1, cyc);

      aw_phase(32'((MEM_WORDS - 2) * 4), 3, 1'b0);
      w_phase(32'((MEM_WORDS - 2) * 4), 3, 32'hD0, -1);
      b_phase();
      ar_phase(32'h0, 1);
      r_phase(32'h0, 1, 0, -1, cyc);
      ar_phase(32'((MEM_WORDS - 2) * 4), 3);
      r_phase(32'((MEM_WORDS - 2) * 4), 3, 0, -1, cyc);
      check("perr_sticky", protocol_error, 1);

      ar_phase(32'h1000, 15);
      r_phase(32'h1000, 15, 0, 4, cyc);
      @(negedge clk);
      reset_n  = 1'b1;
      perr_exp = 1'b0;
      #1;
      check("post_rst_awready", bus.awready, 1);
      check("post_rst_arready", bus.arready, 1);
      check("post_rst_perr", protocol_error, 0);

      aw_phase(32'h5004, 0, 1'b0);
      w_phase(32'h5004, 0, 32'hBEEF, -1);
      b_phase();
      ar_phase(32'h5004, 0);
      r_phase(32'h5004, 0, 0, -1, cyc);
      ar_phase(32'h1000, 0);
      r_phase(32'h1000, 0, 0, -1, cyc);
      check("perr_clean", protocol_error, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
